// File: rtl/step_ctrl_debounce.sv
// step_ctrl_debounce
//   Conditions the two raw step push-buttons for blink_led. Each button is
//   normalised to pressed=1, passed through a 2-flop synchronizer and a
//   stable-count debouncer. A small FSM turns debounced presses into
//   single-cycle step pulses, auto-repeats while a single button is held,
//   and locks out conflicting presses of both buttons.
//
// Ports
//   clk_i      : system clock
//   arstn_i    : asynchronous active-low reset
//   btn_up_i   : raw up button, asynchronous to clk_i
//   btn_dwn_i  : raw down button, asynchronous to clk_i
//   freq_up_o  : registered one-cycle step-up pulse
//   freq_dwn_o : registered one-cycle step-down pulse
//   hold_o     : registered, high while a single-button hold is tracked
module step_ctrl_debounce #(
  parameter int unsigned DEBOUNCE_CYC   = 500000,
  parameter int unsigned REPEAT_DLY_CYC = 25000000,
  parameter int unsigned REPEAT_PER_CYC = 5000000,
  parameter bit          REPEAT_EN      = 1'b1,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic btn_up_i,
  input  logic btn_dwn_i,
  output logic freq_up_o,
  output logic freq_dwn_o,
  output logic hold_o
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned REP_MAX = (REPEAT_DLY_CYC > REPEAT_PER_CYC) ?
                                    REPEAT_DLY_CYC : REPEAT_PER_CYC;
  localparam int unsigned TMR_W   = $clog2(REP_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMR_W-1:0] DLY_LOAD = TMR_W'(REPEAT_DLY_CYC - 1);
  localparam logic [TMR_W-1:0] PER_LOAD = TMR_W'(REPEAT_PER_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_DLY,
    HOLD_RPT,
    LOCKOUT
  } state_t;

  // Bit 0 = up, bit 1 = down throughout.
  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       deb;
  logic [1:0]       deb_q;
  logic [1:0]       press;
  logic [CNT_W-1:0] cnt [2];

  state_t           state;
  state_t           state_nxt;
  logic             dir;
  logic             dir_nxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic             fire;
  logic             up_nxt;
  logic             dwn_nxt;
  logic             hold_nxt;
  logic             active;
  logic             other;

  assign raw    = {btn_dwn_i, btn_up_i} ^ {2{BTN_ACTIVE_LOW}};
  assign press  = deb & ~deb_q;
  assign active = deb[dir];
  assign other  = deb[!dir];

  // Synchronizer and debouncer. The counter only runs while the synced
  // level disagrees with the accepted level; any agreement restarts it, so
  // DEBOUNCE_CYC consecutive disagreeing cycles are needed to flip deb.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // State register; step pulses and hold_o are registered here as well.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state      <= IDLE;
      dir        <= 1'b0;
      timer      <= '0;
      freq_up_o  <= 1'b0;
      freq_dwn_o <= 1'b0;
      hold_o     <= 1'b0;
    end else begin
      state      <= state_nxt;
      dir        <= dir_nxt;
      timer      <= timer_nxt;
      freq_up_o  <= up_nxt;
      freq_dwn_o <= dwn_nxt;
      hold_o     <= hold_nxt;
    end
  end

  // Next-state logic. fire marks the transitions that produce a step pulse.
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    timer_nxt = timer;
    fire      = 1'b0;
    unique case (state)
      IDLE: begin
        if (press[0] && press[1]) begin
          state_nxt = LOCKOUT;
        end else if (press[0] || press[1]) begin
          fire      = 1'b1;
          dir_nxt   = press[1];
          timer_nxt = DLY_LOAD;
          state_nxt = HOLD_DLY;
        end
      end
      HOLD_DLY, HOLD_RPT: begin
        if (other) begin
          state_nxt = LOCKOUT;
        end else if (!active) begin
          state_nxt = IDLE;
        end else if (timer == '0) begin
          // Without auto-repeat the timer parks at zero until release.
          if (REPEAT_EN) begin
            fire      = 1'b1;
            timer_nxt = PER_LOAD;
            state_nxt = HOLD_RPT;
          end
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      LOCKOUT: begin
        if (deb == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode, registered by the state register process.
  always_comb begin
    up_nxt   = fire && !dir_nxt;
    dwn_nxt  = fire && dir_nxt;
    hold_nxt = (state_nxt == HOLD_DLY) || (state_nxt == HOLD_RPT);
  end

endmodule

// File: tb/tb_step_ctrl_debounce.sv
module tb_step_ctrl_debounce;

  logic clk = 1'b0;
  logic arstn;
  logic btn_up;
  logic btn_dwn;
  logic a_up, a_dwn, a_hold;
  logic b_up, b_dwn, b_hold;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int a_up_t[$];
  int a_dwn_t[$];
  int b_up_n    = 0;
  int b_dwn_n   = 0;
  int excl_viol = 0;
  int wide_viol = 0;
  logic a_up_prev = 1'b0, a_dwn_prev = 1'b0, b_up_prev = 1'b0, b_dwn_prev = 1'b0;

  int rpt_exp[6] = '{7, 27, 35, 43, 51, 59};

  step_ctrl_debounce #(
    .DEBOUNCE_CYC  (4),
    .REPEAT_DLY_CYC(20),
    .REPEAT_PER_CYC(8),
    .REPEAT_EN     (1'b1),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut_rpt (
    .clk_i     (clk),
    .arstn_i   (arstn),
    .btn_up_i  (btn_up),
    .btn_dwn_i (btn_dwn),
    .freq_up_o (a_up),
    .freq_dwn_o(a_dwn),
    .hold_o    (a_hold)
  );

  step_ctrl_debounce #(
    .DEBOUNCE_CYC  (4),
    .REPEAT_DLY_CYC(20),
    .REPEAT_PER_CYC(8),
    .REPEAT_EN     (1'b0),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut_norpt (
    .clk_i     (clk),
    .arstn_i   (arstn),
    .btn_up_i  (btn_up),
    .btn_dwn_i (btn_dwn),
    .freq_up_o (b_up),
    .freq_dwn_o(b_dwn),
    .hold_o    (b_hold)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record pulse cycles and watch exclusivity / pulse width.
  always @(negedge clk) begin
    if (arstn) begin
      if (a_up)  a_up_t.push_back(cyc);
      if (a_dwn) a_dwn_t.push_back(cyc);
      if (b_up)  b_up_n++;
      if (b_dwn) b_dwn_n++;
      if ((a_up && a_dwn) || (b_up && b_dwn)) excl_viol++;
      if ((a_up && a_up_prev) || (a_dwn && a_dwn_prev) ||
          (b_up && b_up_prev) || (b_dwn && b_dwn_prev)) wide_viol++;
    end
    a_up_prev  = a_up;
    a_dwn_prev = a_dwn;
    b_up_prev  = b_up;
    b_dwn_prev = b_dwn;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear();
    a_up_t.delete();
    a_dwn_t.delete();
    b_up_n  = 0;
    b_dwn_n = 0;
  endtask

  function automatic int up_at(input int i, input int base);
    return (i < a_up_t.size()) ? a_up_t[i] - base : -1;
  endfunction

  function automatic int dwn_at(input int i, input int base);
    return (i < a_dwn_t.size()) ? a_dwn_t[i] - base : -1;
  endfunction

  initial begin
    int c;
    arstn   = 1'b0;
    btn_up  = 1'b0;
    btn_dwn = 1'b0;

    // Reset with both buttons pressed, then release into a both-press lockout.
    tick(3);
    check("rst_up",   a_up,   0);
    check("rst_dwn",  a_dwn,  0);
    check("rst_hold", a_hold, 0);
    check("rst_b_up", b_up,   0);
    arstn = 1'b1;
    tick(8);
    check("lock_hold", a_hold, 0);
    tick(12);
    btn_up  = 1'b1;
    btn_dwn = 1'b1;
    tick(15);
    check("lock_up_n",   a_up_t.size(),  0);
    check("lock_dwn_n",  a_dwn_t.size(), 0);
    check("lock_b_n",    b_up_n + b_dwn_n, 0);

    // Clean press of up for 10 cycles.
    clear();
    c = cyc;
    btn_up = 1'b0;
    tick(6);
    check("clean_early", a_up, 0);
    tick(1);
    check("clean_pulse", a_up, 1);
    check("clean_hold",  a_hold, 1);
    tick(1);
    check("clean_width", a_up, 0);
    tick(2);
    btn_up = 1'b1;
    tick(15);
    check("clean_n",     a_up_t.size(), 1);
    check("clean_t",     up_at(0, c), 7);
    check("clean_dwn_n", a_dwn_t.size(), 0);
    check("clean_b_n",   b_up_n, 1);
    check("clean_idle",  a_hold, 0);

    // Bouncing down button, then settle pressed.
    clear();
    for (int i = 0; i < 10; i++) begin
      btn_dwn = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(3);
    end
    c = cyc;
    btn_dwn = 1'b0;
    tick(10);
    btn_dwn = 1'b1;
    tick(15);
    check("bounce_n",    a_dwn_t.size(), 1);
    check("bounce_t",    dwn_at(0, c), 7);
    check("bounce_up_n", a_up_t.size(), 0);
    check("bounce_b_n",  b_dwn_n, 1);

    // Auto-repeat: hold up for 60 cycles.
    clear();
    c = cyc;
    btn_up = 1'b0;
    tick(6);
    check("rpt_hold_pre", a_hold, 0);
    tick(1);
    check("rpt_hold_first", a_hold, 1);
    tick(33);
    check("rpt_hold_mid", a_hold, 1);
    check("norpt_hold_mid", b_hold, 1);
    tick(20);
    btn_up = 1'b1;
    tick(6);
    check("rpt_hold_last", a_hold, 1);
    tick(1);
    check("rpt_hold_drop", a_hold, 0);
    tick(10);
    check("rpt_n", a_up_t.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rpt_t%0d", i), up_at(i, c), rpt_exp[i]);
    end
    check("rpt_dwn_n",   a_dwn_t.size(), 0);
    check("norpt_n",     b_up_n, 1);

    // Conflict: down pressed during an up hold.
    clear();
    c = cyc;
    btn_up = 1'b0;
    tick(10);
    btn_dwn = 1'b0;
    tick(6);
    check("conf_hold_pre", a_hold, 1);
    tick(1);
    check("conf_hold_lock", a_hold, 0);
    tick(23);
    btn_up  = 1'b1;
    btn_dwn = 1'b1;
    tick(15);
    check("conf_up_n",  a_up_t.size(), 1);
    check("conf_up_t",  up_at(0, c), 7);
    check("conf_dwn_n", a_dwn_t.size(), 0);
    check("conf_b_n",   b_up_n + b_dwn_n, 1);

    // Recovery after lockout: a plain down press.
    clear();
    c = cyc;
    btn_dwn = 1'b0;
    tick(10);
    btn_dwn = 1'b1;
    tick(15);
    check("recov_n",    a_dwn_t.size(), 1);
    check("recov_t",    dwn_at(0, c), 7);
    check("recov_up_n", a_up_t.size(), 0);

    // Reset asserted while a repeat pulse is high; button stays held.
    clear();
    c = cyc;
    btn_up = 1'b0;
    tick(34);
    @(posedge clk);
    #1;
    check("mr_pulse", a_up, 1);
    check("mr_hold",  a_hold, 1);
    arstn = 1'b0;
    #1;
    check("mr_up_async",   a_up, 0);
    check("mr_hold_async", a_hold, 0);
    tick(3);
    check("mr_up_in_rst", a_up, 0);
    arstn = 1'b1;
    clear();
    c = cyc;
    tick(10);
    btn_up = 1'b1;
    tick(15);
    check("mr_fresh_n", a_up_t.size(), 1);
    check("mr_fresh_t", up_at(0, c), 7);

    check("exclusive", excl_viol, 0);
    check("pulse_width", wide_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
